// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if
// Bundles every non-clock/reset signal of the XM-23 instruction encoder.
//   Run control  : start, base_addr (master -> slave)
//   Input channel: in_valid, in_last, op and operand fields (master -> slave),
//                  in_ready (slave -> master)
//   Output chan. : out_word, out_addr, out_valid, out_last (slave -> master),
//                  out_ready (master -> slave)
//   Status       : count, busy, done, flto (slave -> master)
// master = producer/consumer side (loader or bench), slave = the encoder.
interface instruction_encoder_if #(
  parameter int ADDR_W = 16
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [6:0]        op;
  logic [12:0]       off;
  logic [3:0]        c;
  logic [2:0]        t;
  logic [2:0]        f;
  logic [2:0]        pr;
  logic [3:0]        sa;
  logic [4:0]        pswb;
  logic [2:0]        dst;
  logic [2:0]        srccon;
  logic              wb;
  logic              rc;
  logic [7:0]        imbyte;
  logic              prpo;
  logic              dec;
  logic              inc;

  logic [15:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  logic [15:0]       count;
  logic              busy;
  logic              done;
  logic              flto;

  modport master (
    output start, base_addr,
    output in_valid, in_last, op, off, c, t, f, pr, sa, pswb,
    output dst, srccon, wb, rc, imbyte, prpo, dec, inc,
    input  in_ready,
    input  out_word, out_addr, out_valid, out_last,
    output out_ready,
    input  count, busy, done, flto
  );

  modport slave (
    input  start, base_addr,
    input  in_valid, in_last, op, off, c, t, f, pr, sa, pswb,
    input  dst, srccon, wb, rc, imbyte, prpo, dec, inc,
    output in_ready,
    output out_word, out_addr, out_valid, out_last,
    input  out_ready,
    output count, busy, done, flto
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder
// Packs decoded XM-23 fields (OP 0..41 plus operands) into 16-bit instruction
// words and emits them with a byte address over a valid/ready handshake.
// Run control is IDLE/RUN/DONE/FAULT; an OP above 41 sends the block to FAULT.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    instruction_encoder_if.slave: start/base_addr, input bundle channel,
//          output word channel, count/busy/done/flto status
module instruction_encoder #(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  instruction_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e            state_q;
  logic [15:0]       out_word_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] next_addr_q;   // address the next accepted word will get
  logic              out_valid_q;
  logic              out_last_q;
  logic [15:0]       count_q;

  logic              op_legal;
  logic              in_ready;
  logic              in_fire;
  logic              out_fire;
  logic [3:0]        op_lo;
  logic [15:0]       enc_word;

  assign op_legal = (bus.op <= 7'd41);
  assign out_fire = out_valid_q && bus.out_ready;

  // Start takes priority over a same-cycle bundle. Once the last word of a run
  // is sitting in the output register no further bundle is taken, so the run
  // ends exactly on that word.
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready) &&
                    !bus.start && !(out_valid_q && out_last_q);
  assign in_fire  = bus.in_valid && in_ready;

  // Field packing. op_lo holds OP minus the base of its group; each group only
  // takes as many low bits as its slot has.
  always_comb begin
    op_lo    = 4'd0;
    enc_word = 16'h0000;
    if (bus.op == 7'd0) begin
      enc_word = {3'b000, bus.off};
    end else if (bus.op <= 7'd8) begin
      op_lo    = 4'(bus.op - 7'd1);
      enc_word = {3'b001, op_lo[2:0], bus.off[9:0]};
    end else if (bus.op <= 7'd20) begin
      op_lo    = 4'(bus.op - 7'd9);
      enc_word = {3'b010, 1'b0, op_lo, bus.rc, bus.wb, bus.srccon, bus.dst};
    end else if (bus.op <= 7'd22) begin
      op_lo    = 4'(bus.op - 7'd21);
      enc_word = {6'b010011, 2'b00, op_lo[0], bus.wb, bus.srccon, bus.dst};
    end else if (bus.op <= 7'd27) begin
      op_lo    = 4'(bus.op - 7'd23);
      enc_word = {9'b010011010, bus.wb, op_lo[2:0], bus.dst};
    end else if (bus.op == 7'd28) begin
      enc_word = {13'b0100110110000, bus.pr};
    end else if (bus.op == 7'd29) begin
      enc_word = {12'b010011011001, bus.sa};
    end else if (bus.op == 7'd30) begin
      enc_word = {11'b01001101101, bus.pswb};
    end else if (bus.op == 7'd31) begin
      enc_word = {11'b01001101110, bus.pswb};
    end else if (bus.op == 7'd32) begin
      enc_word = {6'b010100, bus.c, bus.t, bus.f};
    end else if (bus.op <= 7'd34) begin
      op_lo    = 4'(bus.op - 7'd33);
      enc_word = {5'b01011, op_lo[0], bus.prpo, bus.dec, bus.inc,
                  bus.wb, bus.srccon, bus.dst};
    end else if (bus.op <= 7'd38) begin
      op_lo    = 4'(bus.op - 7'd35);
      enc_word = {3'b011, op_lo[1:0], bus.imbyte, bus.dst};
    end else if (bus.op <= 7'd40) begin
      op_lo    = 4'(bus.op - 7'd39);
      enc_word = {1'b1, op_lo[0], bus.off[6:0], bus.wb, bus.srccon, bus.dst};
    end else if (bus.op == 7'd41) begin
      enc_word = {6'b010101, 10'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      out_word_q  <= 16'h0000;
      out_addr_q  <= '0;
      next_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= 16'h0000;
    end else if (bus.start) begin
      // (Re)start from any state; a word still waiting downstream is dropped.
      state_q     <= S_RUN;
      next_addr_q <= bus.base_addr;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= 16'h0000;
    end else begin
      case (state_q)
        S_RUN: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
            if (out_last_q) begin
              state_q <= S_DONE;
            end
          end
          if (in_fire) begin
            if (op_legal) begin
              out_word_q  <= enc_word;
              out_addr_q  <= next_addr_q;
              out_last_q  <= bus.in_last;
              out_valid_q <= 1'b1;
              next_addr_q <= next_addr_q + ADDR_W'(ADDR_STEP);
            end else begin
              // Illegal OP: nothing is emitted and the address is not advanced.
              state_q <= S_FAULT;
            end
          end
        end
        default: begin
          // IDLE, DONE and FAULT only leave on start.
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.count     = count_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.flto      = (state_q == S_FAULT);

endmodule
